// File: rtl/pipe_pkg.sv
// Shared pipeline constants: NOP encoding, reset PC default, 5-bit major opcodes
// and the redirect-address helper used by the fetch stage.
package pipe_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // inst[6:2] major opcodes; inst[1:0] is always 2'b11 for 32-bit encodings
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_FENCE  = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  // Bit 0 of a jump target is architecturally ignored (JALR clears it).
  function automatic logic [31:0] redirect_pc(input logic [31:0] target);
    return {target[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: address out, synchronous read data in.
interface fetch_stage_if;

  logic [31:0] im_addr;
  logic [31:0] im_rdata;

  modport master (output im_addr, input  im_rdata);
  modport slave  (input  im_addr, output im_rdata);

endinterface

// File: rtl/fetch_stage.sv
// F/D stage: PC register, one-entry stall hold buffer and redirect flush bubble.
// Optional sticky misaligned-target flag enabled by FETCH_MISALIGN_CHK_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = pipe_pkg::NOP_INST
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 next_pc_sel,
  input  logic [31:0]          jb_target,
  fetch_stage_if.master        imem,
  output logic [31:0]          D_pc,
  output logic [31:0]          D_inst,
  output logic                 D_valid,
  output logic                 misalign_err
);

  logic [31:0] pc_f;
  logic [31:0] held_inst;
  logic        hold_valid;
  logic        kill;

  // jb_target[0] is dropped by the redirect alignment
  logic        unused_tgt_lsb;
  assign unused_tgt_lsb = jb_target[0];

  assign imem.im_addr = pc_f;

  always_comb begin
    D_inst = imem.im_rdata;
    if (kill)
      D_inst = NOP_INST;
    else if (hold_valid)
      D_inst = held_inst;
  end

  assign D_valid = ~kill;

  // Redirect beats stall: the instruction being held is on the wrong path anyway.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_f       <= RESET_PC;
      D_pc       <= 32'h0;
      held_inst  <= NOP_INST;
      hold_valid <= 1'b0;
      kill       <= 1'b1;
    end else if (next_pc_sel) begin
      pc_f       <= pipe_pkg::redirect_pc(jb_target);
      D_pc       <= pc_f;
      kill       <= 1'b1;
      hold_valid <= 1'b0;
    end else if (stall) begin
      // im_rdata moves on to the word at the held pc_f, so freeze D's copy once
      if (!hold_valid) begin
        held_inst  <= D_inst;
        hold_valid <= 1'b1;
      end
      kill <= 1'b0;
    end else begin
      pc_f       <= pc_f + pipe_pkg::PC_STEP;
      D_pc       <= pc_f;
      kill       <= 1'b0;
      hold_valid <= 1'b0;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      misalign_q <= 1'b0;
    else if (next_pc_sel && jb_target[1])
      misalign_q <= 1'b1;
  end

  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random stall/redirect
// traffic compared against an architectural model of what D should hold.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        next_pc_sel;
  logic [31:0] jb_target;
  logic [31:0] D_pc;
  logic [31:0] D_inst;
  logic        D_valid;
  logic        misalign_err;

  fetch_stage_if imem ();

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .next_pc_sel  (next_pc_sel),
    .jb_target    (jb_target),
    .imem         (imem),
    .D_pc         (D_pc),
    .D_inst       (D_inst),
    .D_valid      (D_valid),
    .misalign_err (misalign_err)
  );

  logic [31:0] mem [0:1023];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem.im_rdata <= mem[imem.im_addr[11:2]];

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model: fetch address, and what D holds (pc, word, valid)
  logic [31:0] m_pc, m_dpc, m_dinst;
  logic        m_dvalid, m_mis;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return mem[a[11:2]];
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_dpc = 32'h0; m_dinst = NOP; m_dvalid = 1'b0; m_mis = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; stall = 1'b0; next_pc_sel = 1'b0; jb_target = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
  endtask

  // One clock edge with the given inputs; the model advances by the same edge.
  task automatic step(input logic s, input logic j, input logic [31:0] t);
    stall = s; next_pc_sel = j; jb_target = t;
    @(posedge clk);
    if (j) begin
      m_dpc = m_pc; m_dinst = NOP; m_dvalid = 1'b0;
      m_pc = t & ~32'h1;
`ifdef FETCH_MISALIGN_CHK_EN
      if (t[1]) m_mis = 1'b1;
`endif
    end else if (s) begin
      m_dvalid = 1'b1;
    end else begin
      m_dpc = m_pc; m_dinst = word_at(m_pc); m_dvalid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; next_pc_sel = 1'b0; jb_target = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (imem.im_addr !== RST_PC) begin n_fail++; $display("FAIL reset_im_addr: got %h expected %h", imem.im_addr, RST_PC); end
    n_tests++; if (D_pc !== 32'h0) begin n_fail++; $display("FAIL reset_d_pc: got %h expected %h", D_pc, 32'h0); end
    n_tests++; if (D_inst !== NOP) begin n_fail++; $display("FAIL reset_d_inst: got %h expected %h", D_inst, NOP); end
    n_tests++; if (D_valid !== 1'b0) begin n_fail++; $display("FAIL reset_d_valid: got %b expected 0", D_valid); end
    n_tests++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", misalign_err); end
  endtask

  task automatic test_sequential();
    do_reset();
    n_tests++; if (D_valid !== 1'b0 || D_inst !== NOP) begin n_fail++; $display("FAIL seq_first_cycle: got valid=%b inst=%h expected valid=0 inst=%h", D_valid, D_inst, NOP); end
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b0, 32'h0);
      n_tests++; if (imem.im_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_im_addr: got %h expected %h", imem.im_addr, 32'(4 * i)); end
      n_tests++; if (D_pc !== 32'(4 * (i - 1)) || D_inst !== mem[i - 1] || D_valid !== 1'b1) begin
        n_fail++; $display("FAIL seq_d: got pc=%h inst=%h valid=%b expected pc=%h inst=%h valid=1", D_pc, D_inst, D_valid, 32'(4 * (i - 1)), mem[i - 1]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (5) step(1'b0, 1'b0, 32'h0);
    n_tests++; if (D_pc !== 32'h10) begin n_fail++; $display("FAIL stall_setup_pc: got %h expected %h", D_pc, 32'h10); end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 32'h0);
      n_tests++; if (D_pc !== 32'h10 || D_inst !== mem[4] || imem.im_addr !== 32'h14) begin
        n_fail++; $display("FAIL stall_hold: got pc=%h inst=%h addr=%h expected pc=10 inst=%h addr=14", D_pc, D_inst, imem.im_addr, mem[4]);
      end
    end
    step(1'b0, 1'b0, 32'h0);
    n_tests++; if (D_pc !== 32'h14 || D_inst !== mem[5]) begin n_fail++; $display("FAIL stall_release: got pc=%h inst=%h expected pc=14 inst=%h", D_pc, D_inst, mem[5]); end
    step(1'b0, 1'b0, 32'h0);
    n_tests++; if (D_pc !== 32'h18 || D_inst !== mem[6]) begin n_fail++; $display("FAIL stall_after: got pc=%h inst=%h expected pc=18 inst=%h", D_pc, D_inst, mem[6]); end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (8) step(1'b0, 1'b0, 32'h0);
    n_tests++; if (imem.im_addr !== 32'h20) begin n_fail++; $display("FAIL redir_setup: got %h expected %h", imem.im_addr, 32'h20); end
    step(1'b0, 1'b1, 32'h101);
    n_tests++; if (imem.im_addr !== 32'h100) begin n_fail++; $display("FAIL redir_im_addr: got %h expected %h", imem.im_addr, 32'h100); end
    n_tests++; if (D_inst !== NOP || D_valid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble: got inst=%h valid=%b expected inst=%h valid=0", D_inst, D_valid, NOP); end
    step(1'b0, 1'b0, 32'h0);
    n_tests++; if (D_pc !== 32'h100 || D_inst !== mem[64] || D_valid !== 1'b1) begin
      n_fail++; $display("FAIL redir_target: got pc=%h inst=%h valid=%b expected pc=100 inst=%h valid=1", D_pc, D_inst, D_valid, mem[64]);
    end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    repeat (3) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h40);
    n_tests++; if (imem.im_addr !== 32'h40 || D_valid !== 1'b0 || D_inst !== NOP) begin
      n_fail++; $display("FAIL stall_redir: got addr=%h valid=%b inst=%h expected addr=40 valid=0 inst=%h", imem.im_addr, D_valid, D_inst, NOP);
    end
    step(1'b0, 1'b0, 32'h0);
    n_tests++; if (D_pc !== 32'h40 || D_inst !== mem[16]) begin n_fail++; $display("FAIL stall_redir_next: got pc=%h inst=%h expected pc=40 inst=%h", D_pc, D_inst, mem[16]); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    repeat (4) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    n_tests++; if (imem.im_addr !== RST_PC) begin n_fail++; $display("FAIL rst_mid_addr: got %h expected %h", imem.im_addr, RST_PC); end
    n_tests++; if (D_inst !== NOP || D_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_d: got inst=%h valid=%b expected inst=%h valid=0", D_inst, D_valid, NOP); end
    @(posedge clk);
    #1;
    model_reset();
    stall = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++; if (D_inst !== NOP || D_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_release: got inst=%h valid=%b expected inst=%h valid=0", D_inst, D_valid, NOP); end
    step(1'b0, 1'b0, 32'h0);
    n_tests++; if (D_pc !== 32'h0 || D_inst !== mem[0]) begin n_fail++; $display("FAIL rst_mid_first: got pc=%h inst=%h expected pc=0 inst=%h", D_pc, D_inst, mem[0]); end
  endtask

  task automatic test_wrap();
    do_reset();
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0);
    n_tests++; if (imem.im_addr !== 32'h0 || D_pc !== 32'hFFFF_FFFC || D_inst !== mem[1023]) begin
      n_fail++; $display("FAIL wrap: got addr=%h pc=%h inst=%h expected addr=0 pc=fffffffc inst=%h", imem.im_addr, D_pc, D_inst, mem[1023]);
    end
    step(1'b0, 1'b0, 32'h0);
    n_tests++; if (D_pc !== 32'h0 || D_inst !== mem[0]) begin n_fail++; $display("FAIL wrap_next: got pc=%h inst=%h expected pc=0 inst=%h", D_pc, D_inst, mem[0]); end
  endtask

  task automatic test_random();
    logic s, j;
    logic [31:0] t;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 99) < 30);
      j = ($urandom_range(0, 99) < 12);
      t = 32'($urandom_range(0, 32'hFFF));
      step(s, j, t);
      n_tests++;
      if (imem.im_addr !== m_pc || D_pc !== m_dpc || D_inst !== m_dinst || D_valid !== m_dvalid || misalign_err !== m_mis) begin
        n_fail++;
        $display("FAIL random[%0d]: got addr=%h pc=%h inst=%h valid=%b mis=%b expected addr=%h pc=%h inst=%h valid=%b mis=%b",
                 i, imem.im_addr, D_pc, D_inst, D_valid, misalign_err, m_pc, m_dpc, m_dinst, m_dvalid, m_mis);
      end
    end
  endtask

  task automatic test_misalign();
    do_reset();
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h102);
    n_tests++; if (imem.im_addr !== 32'h102) begin n_fail++; $display("FAIL mis_redirect: got %h expected %h", imem.im_addr, 32'h102); end
`ifdef FETCH_MISALIGN_CHK_EN
    n_tests++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_set: got %b expected 1", misalign_err); end
    repeat (2) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h200);
    step(1'b0, 1'b0, 32'h0);
    n_tests++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_sticky: got %b expected 1", misalign_err); end
    do_reset();
    n_tests++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_cleared: got %b expected 0", misalign_err); end
`else
    n_tests++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_tied: got %b expected 0", misalign_err); end
`endif
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; next_pc_sel = 1'b0; jb_target = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_stall_redirect();
    test_reset_mid_stall();
    test_wrap();
    test_random();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
